// File: rtl/dram_resp_pkg.sv
// Shared constants and FSM state type for the DRAM responder.
package dram_resp_pkg;
    localparam int MA_W   = 11;
    localparam int COL_W  = 9;
    localparam int DATA_W = 64;
    localparam int NBANK  = 2;
    localparam int LANES  = DATA_W / 8;
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int ADDR_W = BANK_W + MA_W + COL_W;

    typedef enum logic [1:0] {IDLE, REQ, DRIVE, HOLD} state_t;
endpackage

// File: rtl/dram_resp_if.sv
// DRAM pin bundle plus backing-memory port seen by the responder.
interface dram_resp_if
    import dram_resp_pkg::*;
#(
    parameter int MA_W   = dram_resp_pkg::MA_W,
    parameter int COL_W  = dram_resp_pkg::COL_W,
    parameter int DATA_W = dram_resp_pkg::DATA_W,
    parameter int NBANK  = dram_resp_pkg::NBANK
);
    localparam int LANES  = DATA_W / 8;
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int ADDR_W = BANK_W + MA_W + COL_W;

    logic [MA_W-1:0]   ma;
    logic [NBANK-1:0]  rasl;
    logic [LANES-1:0]  casl;
    logic              wel;
    logic              oel;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              refresh;
    logic              proto_err;

    modport slave (
        input  ma, rasl, casl, wel, oel, d_in, mem_ack, mem_rdata,
        output d_out, d_oe, mem_req, mem_we, mem_addr, mem_be, mem_wdata, refresh, proto_err
    );
    modport master (
        output ma, rasl, casl, wel, oel, d_in, mem_ack, mem_rdata,
        input  d_out, d_oe, mem_req, mem_we, mem_addr, mem_be, mem_wdata, refresh, proto_err
    );
endinterface

// File: rtl/dram_strobe_edge.sv
// Registers the RAS/CAS strobes and flags their falling/rising transitions.
module dram_strobe_edge
    import dram_resp_pkg::*;
#(
    parameter int NBANK = dram_resp_pkg::NBANK,
    parameter int LANES = dram_resp_pkg::LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBANK-1:0] rasl,
    input  logic [LANES-1:0] casl,
    output logic [NBANK-1:0] ras_fall,
    output logic [NBANK-1:0] ras_rise,
    output logic             cas_fall,
    output logic             cas_all_high
);
    logic [NBANK-1:0] ras_prev;
    logic [LANES-1:0] cas_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_prev <= '1;
            cas_prev <= '1;
        end else begin
            ras_prev <= rasl;
            cas_prev <= casl;
        end
    end

    // A CAS fall is the whole lane group leaving the all-high state.
    assign ras_fall     = ras_prev & ~rasl;
    assign ras_rise     = ~ras_prev & rasl;
    assign cas_all_high = &casl;
    assign cas_fall     = (&cas_prev) & ~(&casl);
endmodule

// File: rtl/dram_resp.sv
// Emulates DRAM chips: latches row/column strobes and turns each CAS cycle into a word request.
module dram_resp
    import dram_resp_pkg::*;
#(
    parameter int MA_W   = dram_resp_pkg::MA_W,
    parameter int COL_W  = dram_resp_pkg::COL_W,
    parameter int DATA_W = dram_resp_pkg::DATA_W,
    parameter int NBANK  = dram_resp_pkg::NBANK
) (
    input  logic       sys_clk,
    input  logic       resetl,
    dram_resp_if.slave bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int ADDR_W = BANK_W + MA_W + COL_W;

    logic [NBANK-1:0]  ras_fall, ras_rise, active;
    logic              cas_fall, cas_all_high;
    logic [MA_W-1:0]   row [NBANK];
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LANES-1:0]  be_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q, dout_q;
    logic              refresh_q, err_q, discard_q;
    logic [BANK_W-1:0] sel, req_bank;
    logic              start, multi, discard_set, discard;

    dram_strobe_edge #(.NBANK(NBANK), .LANES(LANES)) u_edge (
        .clk          (sys_clk),
        .rst_n        (resetl),
        .rasl         (bus.rasl),
        .casl         (bus.casl),
        .ras_fall     (ras_fall),
        .ras_rise     (ras_rise),
        .cas_fall     (cas_fall),
        .cas_all_high (cas_all_high)
    );

    // Lowest-index active bank wins when more than one RAS is low.
    always_comb begin
        sel = '0;
        for (int i = NBANK - 1; i >= 0; i--) begin
            if (active[i]) sel = BANK_W'(i);
        end
    end

    assign multi       = (active & (active - NBANK'(1))) != '0;
    assign start       = cas_fall && (state == IDLE) && (|active);
    assign req_bank    = addr_q[ADDR_W-1 -: BANK_W];
    assign discard_set = (state == REQ) && ras_rise[req_bank];
    assign discard     = discard_q || discard_set;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (bus.mem_ack) state_nx = (we_q || discard) ? HOLD : DRIVE;
            DRIVE:   if (cas_all_high) state_nx = IDLE;
            HOLD:    if (cas_all_high) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state     <= IDLE;
            active    <= '0;
            for (int i = 0; i < NBANK; i++) row[i] <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dout_q    <= '0;
            refresh_q <= 1'b0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state <= state_nx;
            for (int i = 0; i < NBANK; i++) begin
                if (ras_fall[i] && cas_all_high) begin
                    row[i]    <= bus.ma;
                    active[i] <= 1'b1;
                end else if (ras_rise[i]) begin
                    active[i] <= 1'b0;
                end
            end
            refresh_q <= (|ras_fall) && !cas_all_high;
            if (start) begin
                addr_q    <= {sel, row[sel], bus.ma[COL_W-1:0]};
                be_q      <= ~bus.casl;
                we_q      <= ~bus.wel;
                wdata_q   <= bus.d_in;
                discard_q <= 1'b0;
            end else if (discard_set) begin
                discard_q <= 1'b1;
            end
            if ((state == REQ) && bus.mem_ack && !we_q && !discard)
                dout_q <= bus.mem_rdata;
            if (cas_fall && ((state != IDLE) || !(|active) || multi))
                err_q <= 1'b1;
            if ((state == REQ) && (discard_set || (~bus.wel != we_q)))
                err_q <= 1'b1;
        end
    end

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.d_out     = dout_q;
    assign bus.d_oe      = (state == DRIVE) && !bus.oel && !cas_all_high && bus.wel;
    assign bus.refresh   = refresh_q;
    assign bus.proto_err = err_q;
endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: read, write, page mode, overrun, CBR refresh, reset in REQ.
module tb_dram_resp;
    logic sys_clk = 1'b0;
    logic resetl  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    dram_resp_if bus ();

    dram_resp dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.ma = '0; bus.rasl = '1; bus.casl = '1; bus.wel = 1'b1; bus.oel = 1'b1;
        bus.d_in = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        step(2);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_d_oe", 64'(bus.d_oe), 64'd0);
        chk("rst_refresh", 64'(bus.refresh), 64'd0);
        chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
        chk("rst_d_out", bus.d_out, 64'd0);
        resetl = 1'b1;
        step(1);

        // Read
        bus.rasl = 2'b10; bus.ma = 11'h123; step(1);
        bus.ma = 11'h045; bus.casl = 8'h00; bus.wel = 1'b1; bus.oel = 1'b0; step(1);
        chk("rd_req", 64'(bus.mem_req), 64'd1);
        chk("rd_we", 64'(bus.mem_we), 64'd0);
        chk("rd_be", 64'(bus.mem_be), 64'hFF);
        chk("rd_addr", 64'(bus.mem_addr), 64'h24645);
        chk("rd_oe_in_req", 64'(bus.d_oe), 64'd0);
        step(2);
        chk("rd_req_held", 64'(bus.mem_req), 64'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'hDEADBEEF_01234567; step(1);
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        chk("rd_req_drop", 64'(bus.mem_req), 64'd0);
        chk("rd_d_out", bus.d_out, 64'hDEADBEEF_01234567);
        chk("rd_d_oe", 64'(bus.d_oe), 64'd1);
        step(1);
        chk("rd_d_oe_hold", 64'(bus.d_oe), 64'd1);
        bus.casl = 8'hFF; #1;
        chk("rd_d_oe_off", 64'(bus.d_oe), 64'd0);
        step(1);
        bus.oel = 1'b1; bus.rasl = 2'b11; step(1);
        chk("rd_d_out_kept", bus.d_out, 64'hDEADBEEF_01234567);
        chk("rd_err", 64'(bus.proto_err), 64'd0);

        // Write
        bus.rasl = 2'b01; bus.ma = 11'h7FF; step(1);
        bus.ma = 11'h0AB; bus.casl = 8'hF0; bus.wel = 1'b0; bus.oel = 1'b0;
        bus.d_in = 64'hAAAAAAAA_AAAAAAAA; step(1);
        chk("wr_req", 64'(bus.mem_req), 64'd1);
        chk("wr_we", 64'(bus.mem_we), 64'd1);
        chk("wr_be", 64'(bus.mem_be), 64'h0F);
        chk("wr_addr", 64'(bus.mem_addr), 64'h1FFEAB);
        chk("wr_wdata", bus.mem_wdata, 64'hAAAAAAAA_AAAAAAAA);
        chk("wr_d_oe_req", 64'(bus.d_oe), 64'd0);
        bus.mem_ack = 1'b1; step(1);
        bus.mem_ack = 1'b0;
        chk("wr_req_drop", 64'(bus.mem_req), 64'd0);
        chk("wr_d_oe_hold", 64'(bus.d_oe), 64'd0);
        chk("wr_d_out_same", bus.d_out, 64'hDEADBEEF_01234567);
        bus.casl = 8'hFF; step(1);
        bus.wel = 1'b1; bus.oel = 1'b1; bus.rasl = 2'b11; step(1);
        chk("wr_err", 64'(bus.proto_err), 64'd0);

        // Page mode
        bus.rasl = 2'b10; bus.ma = 11'h123; step(1);
        for (int c = 0; c < 4; c++) begin
            bus.ma = 11'(c); bus.casl = 8'h00; step(1);
            chk("pg_req", 64'(bus.mem_req), 64'd1);
            chk("pg_addr", 64'(bus.mem_addr), 64'h24600 + 64'(c));
            bus.mem_ack = 1'b1; bus.mem_rdata = 64'h100 + 64'(c); step(1);
            bus.mem_ack = 1'b0;
            chk("pg_d_out", bus.d_out, 64'h100 + 64'(c));
            bus.casl = 8'hFF; step(1);
        end
        chk("pg_err", 64'(bus.proto_err), 64'd0);
        bus.rasl = 2'b11; step(1);

        // Overrun
        bus.rasl = 2'b10; bus.ma = 11'h123; step(1);
        bus.ma = 11'h010; bus.casl = 8'h00; bus.oel = 1'b0; step(1);
        chk("ov_req", 64'(bus.mem_req), 64'd1);
        bus.casl = 8'hFF; step(1);
        bus.ma = 11'h020; bus.casl = 8'h00; step(1);
        chk("ov_err", 64'(bus.proto_err), 64'd1);
        chk("ov_addr", 64'(bus.mem_addr), 64'h24610);
        chk("ov_req_held", 64'(bus.mem_req), 64'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'h55; step(1);
        bus.mem_ack = 1'b0;
        chk("ov_d_out", bus.d_out, 64'h55);
        chk("ov_d_oe", 64'(bus.d_oe), 64'd1);
        bus.casl = 8'hFF; step(1);
        bus.oel = 1'b1; bus.rasl = 2'b11; step(1);

        // CBR refresh
        bus.ma = 11'h3AA; bus.casl = 8'h00; step(1);
        bus.rasl = 2'b10; step(1);
        chk("cbr_pulse", 64'(bus.refresh), 64'd1);
        chk("cbr_no_req", 64'(bus.mem_req), 64'd0);
        step(1);
        chk("cbr_pulse_end", 64'(bus.refresh), 64'd0);
        bus.casl = 8'hFF; step(1);
        bus.casl = 8'h00; step(1);
        chk("cbr_no_row", 64'(bus.mem_req), 64'd0);
        bus.casl = 8'hFF; bus.rasl = 2'b11; step(1);

        // Reset in REQ
        bus.rasl = 2'b10; bus.ma = 11'h111; step(1);
        bus.ma = 11'h005; bus.casl = 8'h00; bus.oel = 1'b0; step(1);
        chk("rr_req", 64'(bus.mem_req), 64'd1);
        #2 resetl = 1'b0;
        #1;
        chk("rr_req_drop", 64'(bus.mem_req), 64'd0);
        chk("rr_d_oe", 64'(bus.d_oe), 64'd0);
        chk("rr_refresh", 64'(bus.refresh), 64'd0);
        chk("rr_err_clr", 64'(bus.proto_err), 64'd0);
        bus.rasl = 2'b11; bus.casl = 8'hFF; bus.oel = 1'b1;
        step(1);
        resetl = 1'b1;
        step(2);
        chk("rr_idle_req", 64'(bus.mem_req), 64'd0);
        bus.rasl = 2'b10; bus.ma = 11'h222; step(1);
        bus.ma = 11'h007; bus.casl = 8'h00; step(1);
        chk("rr_new_req", 64'(bus.mem_req), 64'd1);
        chk("rr_new_addr", 64'(bus.mem_addr), 64'h44407);
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'h77; step(1);
        bus.mem_ack = 1'b0;
        chk("rr_new_d_out", bus.d_out, 64'h77);
        bus.casl = 8'hFF; step(1);
        bus.rasl = 2'b11; step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dram_resp.md
Name: dram_resp

Overview:
- Responder end of the multiplexed DRAM address bus generated by the memory controller's address path (ma[10:0], RAS/CAS/WE/OE strobes).
- Captures the row on RAS fall and the column on CAS fall, then turns each CAS cycle into a linear word request on the FPGA-side backing-memory port.
- Returns read data onto the DRAM data bus with a single output enable.
- Sits between the controller's DRAM pins and the SDRAM/BRAM arbiter; it replaces the physical DRAM chips.

Parameters:
MA_W, 11, width of the multiplexed address bus ma.
COL_W, 9, number of ma bits used as the column address (ma[COL_W-1:0]).
DATA_W, 64, DRAM data bus width; byte lanes = DATA_W/8.
NBANK, 2, number of RAS lines (banks).

Ports:
sys_clk  in  1  system clock; every strobe is synchronous to it.
resetl  in  1  asynchronous active-low reset.
ma  in  MA_W  multiplexed row/column address.
rasl  in  NBANK  row strobes, active low.
casl  in  DATA_W/8  per-byte column strobes, active low.
wel  in  1  write enable, active low.
oel  in  1  output enable, active low.
d_in  in  DATA_W  write data from the controller.
d_out  out  DATA_W  read data toward the controller.
d_oe  out  1  single enable for all d_out bits.
mem_req  out  1  backing-memory request; held high until mem_ack.
mem_we  out  1  1 = write request.
mem_addr  out  log2(NBANK)+MA_W+COL_W  word address {bank,row,col}.
mem_be  out  DATA_W/8  byte enables (~casl at capture).
mem_wdata  out  DATA_W  write data.
mem_ack  in  1  one-cycle acknowledge; read data is valid in the same cycle.
mem_rdata  in  DATA_W  read data.
refresh  out  1  one-cycle pulse on each CAS-before-RAS refresh.
proto_err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset clears all outputs, row registers, bank-active bits and the previous-strobe registers. Previous strobes reset to all-high. The FSM resets to IDLE.
- Reset mid-request drops mem_req at once. The backing side must tolerate an abandoned request.
- Edge detection compares each registered strobe with its previous value. A fall is prev=1, now=0.
- RAS fall on bank b while all casl are high: row[b] <= ma, active[b] <= 1.
- RAS rise on bank b: active[b] <= 0.
- Refresh (CBR):
  - Condition: any casl already low when a RAS falls.
  - Pulse refresh for 1 cycle.
  - No row latch and no request.
- CAS fall is the transition from all-high to any-low.
- With exactly one bank active, in IDLE: capture col = ma[COL_W-1:0], be = ~casl, we = ~wel, wdata = d_in.
  - Next cycle: mem_req=1 and state REQ.
- Page mode: further CAS falls under the same RAS reuse the latched row.
- FSM states:
  - IDLE: wait for a valid CAS fall.
  - REQ: hold mem_req and all mem_* fields stable. On mem_ack: drop mem_req.
    - Write: go to HOLD.
    - Read: register mem_rdata into d_out, go to DRIVE.
  - DRIVE: d_oe = ~oel & (any casl low). On the cycle all casl are high: d_oe=0, go to IDLE.
  - HOLD: on the cycle all casl are high, go to IDLE.
- Latency: CAS fall sampled at cycle N gives mem_req at N+1. With ack at N+k, d_out is valid and d_oe may assert at N+k+1.
- d_out keeps its last value after DRIVE. Only d_oe drops.
- Error conditions (all set proto_err):
  - CAS fall while not IDLE: the access is ignored.
  - CAS fall with no bank active.
  - Two banks active at a CAS fall: the lowest-index bank wins.
  - RAS rise in REQ: the request still completes and its data is discarded.
  - wel changing while in REQ.
- d_oe is never asserted while wel is low.

Decomposition:
- Package dram_resp_pkg holds:
  - parameter defaults;
  - the derived widths LANES = DATA_W/8 and BANK_W = clog2(NBANK);
  - the state enum {IDLE, REQ, DRIVE, HOLD}.
- Sub-module dram_strobe_edge registers rasl/casl and produces per-bank RAS fall/rise, the any-CAS fall, and all-CAS-high.

Test Plan:
- Read: RAS0 fall with ma=0x123, then CAS fall (all lanes) with ma=0x045, wel=1, oel=0; ack after 3 cycles with rdata=0xDEADBEEF_01234567 -> mem_addr={0,0x123,0x045}, mem_we=0, mem_be=0xFF; d_out equals rdata with d_oe=1 until CAS rises.
- Write: RAS1 fall row 0x7FF; CAS fall with casl=0xF0, wel=0, d_in=0xAA..AA -> mem_we=1, mem_be=0x0F, mem_addr={1,0x7FF,col}; d_oe stays 0 throughout.
- Page mode: one RAS0 fall, then 4 CAS cycles with cols 0..3 -> 4 requests, all with row 0x123 and cols 0,1,2,3; proto_err=0.
- CBR refresh: casl low before RAS0 falls -> refresh pulses for exactly 1 cycle; no mem_req; row[0] unchanged.
- Overrun: a second CAS fall while in REQ -> ignored, proto_err=1; the first request completes normally.
- Async reset asserted in REQ -> mem_req, d_oe and refresh go to 0 within the same cycle; FSM is IDLE after release.
